// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD_CTRL command path: opcodes, issuer states, defaults.
package lcd_pkg;

    localparam int FIFO_DEPTH  = 8;
    localparam int TIMEOUT_DEF = 256;

    localparam logic [3:0] CMD_WRITE = 4'd0;
    localparam logic [3:0] CMD_UP    = 4'd1;
    localparam logic [3:0] CMD_DOWN  = 4'd2;
    localparam logic [3:0] CMD_LEFT  = 4'd3;
    localparam logic [3:0] CMD_RIGHT = 4'd4;
    localparam logic [3:0] CMD_MAX   = 4'd5;
    localparam logic [3:0] CMD_MIN   = 4'd6;
    localparam logic [3:0] CMD_AVG   = 4'd7;
    localparam logic [3:0] CMD_CCW   = 4'd8;
    localparam logic [3:0] CMD_CW    = 4'd9;
    localparam logic [3:0] CMD_MIRX  = 4'd10;
    localparam logic [3:0] CMD_MIRY  = 4'd11;
    localparam logic [3:0] CMD_COPY  = 4'd12;
    localparam logic [3:0] CMD_PASTE = 4'd13;
    localparam logic [3:0] CMD_NOP   = 4'd14;
    localparam logic [3:0] CMD_DONE  = 4'd15;

    typedef enum logic [2:0] {
        ST_RDY,
        ST_ISSUE,
        ST_ACK,
        ST_WAIT,
        ST_FIN,
        ST_ERR
    } issuer_state_t;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// DEPTH x 4 synchronous command FIFO with full/empty flags and an occupancy count.
module lcd_cmd_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [3:0]               din,
    input  logic                     pop,
    output logic [3:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_cmd_issuer.sv
// Issues buffered opcodes to the LCD_CTRL engine one at a time, paced by busy, with
// completion tracking, a saturating issue counter and sticky timeout/ack error detection.
module lcd_cmd_issuer
    import lcd_pkg::*;
#(
    parameter int DEPTH   = FIFO_DEPTH,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  in_cmd,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        lcd_busy,
    input  logic        lcd_done,
    output logic [3:0]  cmd,
    output logic        cmd_valid,
    output logic [15:0] issued_cnt,
    output logic        finished,
    output logic        error
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT);

    issuer_state_t state, state_n;

    logic [3:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          pop;

    logic [TW-1:0] tmo, tmo_n;
    logic [3:0]    last_op;
    logic          set_err;
    logic          set_fin;
    logic          cnt_inc;

    assign in_ready = (fifo_count != CW'(DEPTH));

    lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && !fifo_full),
        .din   (in_cmd),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_RDY;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        tmo_n   = tmo;
        pop     = 1'b0;
        set_err = 1'b0;
        set_fin = 1'b0;
        cnt_inc = 1'b0;
        case (state)
            ST_RDY: begin
                // A queued NOP is dropped here so it never reaches the engine or the counter.
                if (!lcd_busy && !fifo_empty) begin
                    pop = 1'b1;
                    if (fifo_dout != CMD_NOP)
                        state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: state_n = ST_ACK;
            ST_ACK: begin
                if (lcd_busy) begin
                    cnt_inc = 1'b1;
                    tmo_n   = TW'(1);
                    state_n = (last_op == CMD_DONE) ? ST_FIN : ST_WAIT;
                end else begin
                    set_err = 1'b1;
                    state_n = ST_ERR;
                end
            end
            ST_WAIT, ST_FIN: begin
                if (state == ST_FIN && lcd_done)
                    set_fin = 1'b1;
                if (!lcd_busy) begin
                    tmo_n = '0;
                    if (state == ST_WAIT)
                        state_n = ST_RDY;
                end else if (tmo == TW'(TIMEOUT - 1)) begin
                    set_err = 1'b1;
                    state_n = ST_ERR;
                end else begin
                    tmo_n = tmo + TW'(1);
                end
            end
            ST_ERR:  state_n = ST_ERR;
            default: state_n = ST_ERR;
        endcase
    end

    // cmd/cmd_valid are registered from the next state so they are live only during ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo        <= '0;
            last_op    <= CMD_NOP;
            cmd        <= CMD_NOP;
            cmd_valid  <= 1'b0;
            issued_cnt <= '0;
            finished   <= 1'b0;
            error      <= 1'b0;
        end else begin
            tmo       <= tmo_n;
            cmd_valid <= (state_n == ST_ISSUE);
            cmd       <= (state_n == ST_ISSUE) ? fifo_dout : CMD_NOP;
            if (state == ST_RDY && state_n == ST_ISSUE)
                last_op <= fifo_dout;
            if (cnt_inc && issued_cnt != 16'hFFFF)
                issued_cnt <= issued_cnt + 16'd1;
            if (set_fin)
                finished <= 1'b1;
            if (set_err)
                error <= 1'b1;
        end
    end

endmodule
